post_feed: RTL

POST_FEED -- requirements
Module: post_feed

---
 rtl/post_feed.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/post_feed.sv
// Accumulator-to-post-processing feeder: forwards accepted accumulator beats with one
// cycle of latency, tagging each beat with its output channel's scale (K) and bias (B).
module post_feed #(
    parameter int POX     = 3,
    parameter int NOF_MAX = 16,
    localparam int AW     = $clog2(NOF_MAX)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                param_wr_en,
    input  logic [AW-1:0]       param_wr_addr,
    input  logic [15:0]         param_wr_k,
    input  logic [15:0]         param_wr_b,
    input  logic [AW:0]         cfg_nof,
    input  logic [15:0]         cfg_ngrp,
    input  logic                start,
    output logic                busy,
    output logic                done,
    input  logic [POX*16-1:0]   acc_data,
    input  logic                acc_valid,
    output logic                acc_ready,
    output logic [POX*16-1:0]   mux_postprocess_data,
    output logic                mux_postprocess_valid,
    output logic [POX*16-1:0]   K,
    output logic [POX*16-1:0]   B
);

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic [31:0]         table_r [NOF_MAX];
    logic [AW-1:0]       ch_cnt_r;
    logic [15:0]         grp_cnt_r;
    logic [AW:0]         nof_r;
    logic [15:0]         ngrp_r;
    logic                done_r;
    logic                valid_r;
    logic [POX*16-1:0]   data_r;
    logic [POX*16-1:0]   k_r;
    logic [POX*16-1:0]   b_r;
    logic                busy_s;
    logic                acc_ready_s;
    logic                accept_s;
    logic                last_ch_s;
    logic                last_grp_s;
    logic                cfg_zero_s;
    logic                idle_start_s;
    logic [31:0]         entry_s;

    assign accept_s     = acc_valid & acc_ready_s;
    assign last_ch_s    = ({1'b0, ch_cnt_r} == (nof_r - (AW+1)'(1)));
    assign last_grp_s   = (grp_cnt_r == (ngrp_r - 16'd1));
    assign cfg_zero_s   = (cfg_nof == {(AW+1){1'b0}}) | (cfg_ngrp == 16'd0);
    assign idle_start_s = (state_r == IDLE) & start;
    assign entry_s      = table_r[ch_cnt_r];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; an empty run never leaves IDLE
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && !cfg_zero_s) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (accept_s && last_ch_s && last_grp_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RUN;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy_s      = 1'b0;
        acc_ready_s = 1'b0;
        case (state_r)
            IDLE: begin
                busy_s      = 1'b0;
                acc_ready_s = 1'b0;
            end
            RUN: begin
                busy_s      = 1'b1;
                acc_ready_s = 1'b1;
            end
            default: begin
                busy_s      = 1'b0;
                acc_ready_s = 1'b0;
            end
        endcase
    end

    assign busy      = busy_s;
    assign acc_ready = acc_ready_s;

    // K/B table, writable only while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NOF_MAX; i++) begin
                table_r[i] <= 32'd0;
            end
        end else if (param_wr_en && (state_r == IDLE)) begin
            table_r[param_wr_addr] <= {param_wr_k, param_wr_b};
        end
    end

    // Run configuration latch and channel/group counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_cnt_r  <= {AW{1'b0}};
            grp_cnt_r <= 16'd0;
            nof_r     <= {(AW+1){1'b0}};
            ngrp_r    <= 16'd0;
        end else if (idle_start_s) begin
            ch_cnt_r  <= {AW{1'b0}};
            grp_cnt_r <= 16'd0;
            nof_r     <= cfg_nof;
            ngrp_r    <= cfg_ngrp;
        end else if (accept_s) begin
            if (last_ch_s) begin
                ch_cnt_r  <= {AW{1'b0}};
                grp_cnt_r <= last_grp_s ? 16'd0 : (grp_cnt_r + 16'd1);
            end else begin
                ch_cnt_r  <= ch_cnt_r + AW'(1);
            end
        end
    end

    // Output stage: one-cycle forward of accepted beats; lanes hold between beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            data_r  <= {(POX*16){1'b0}};
            k_r     <= {(POX*16){1'b0}};
            b_r     <= {(POX*16){1'b0}};
        end else begin
            valid_r <= accept_s;
            done_r  <= (idle_start_s & cfg_zero_s) | (accept_s & last_ch_s & last_grp_s);
            if (accept_s) begin
                data_r <= acc_data;
                k_r    <= {POX{entry_s[31:16]}};
                b_r    <= {POX{entry_s[15:0]}};
            end
        end
    end

    assign mux_postprocess_data  = data_r;
    assign mux_postprocess_valid = valid_r;
    assign K                     = k_r;
    assign B                     = b_r;
    assign done                  = done_r;

endmodule
